// File: rtl/dds_hop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dds_hop_sequencer
// Description : Frequency-hop controller for the DDS block. Holds a small
//               programmable table of phase-increment/dwell pairs and issues
//               each slot's increment to the DDS as a one-cycle strobe. It
//               then holds that slot for its dwell time and advances, either
//               one-shot or looping.
//               Optional macro DDS_HOP_PHRST_EN adds a phRst output. It pulses
//               with every valPhInc to clear the DDS phase accumulator, which
//               gives phase-coherent hops.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_hop_sequencer #(
    parameter  int PHINCWIDTH = 16,
    parameter  int DWELLWIDTH = 16,
    parameter  int NSLOTS     = 8,
    localparam int ADDRW      = $clog2(NSLOTS)
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active-low
    input  logic                  cfgWe,
    input  logic [ADDRW-1:0]      cfgAddr,
    input  logic [PHINCWIDTH-1:0] cfgPhInc,
    input  logic [DWELLWIDTH-1:0] cfgDwell,
    input  logic [ADDRW:0]        numSlots,
    input  logic                  loop,
    input  logic                  start,
    input  logic                  stop,
    output logic [PHINCWIDTH-1:0] phInc,
    output logic                  valPhInc,
    output logic                  busy,
    output logic [ADDRW-1:0]      slot,
    output logic                  done
`ifdef DDS_HOP_PHRST_EN
    ,
    output logic                  phRst
`endif
);

    // ------------------------------------------------------------------------
    // Constants sized to the vectors they are combined with
    // ------------------------------------------------------------------------
    localparam logic [ADDRW:0]        NSLOTS_N = (ADDRW+1)'(NSLOTS);
    localparam logic [ADDRW:0]        ONE_N    = (ADDRW+1)'(1);
    localparam logic [ADDRW-1:0]      ONE_A    = ADDRW'(1);
    localparam logic [DWELLWIDTH-1:0] ONE_D    = DWELLWIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DWELL  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state;
    logic [ADDRW-1:0]        idx;
    logic [ADDRW:0]          n_reg;
    logic [DWELLWIDTH-1:0]   cnt;

    logic [PHINCWIDTH-1:0]   tbl_ph    [NSLOTS];
    logic [DWELLWIDTH-1:0]   tbl_dwell [NSLOTS];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [PHINCWIDTH-1:0]   cur_ph;
    logic [DWELLWIDTH-1:0]   cur_dwell;
    logic                    single_cycle;
    logic [DWELLWIDTH-1:0]   cnt_load;
    logic                    start_ok;
    logic                    is_last;
    state_t                  adv_state;
    logic [ADDRW-1:0]        adv_idx;

    // Current slot lookup, effective-dwell handling and the advance decision
    always_comb begin
        cur_ph       = tbl_ph[idx];
        cur_dwell    = tbl_dwell[idx];
        // A dwell of 0 behaves exactly like a dwell of 1
        single_cycle = (cur_dwell <= ONE_D);
        cnt_load     = single_cycle ? '0 : (cur_dwell - ONE_D);
        // Stop in the same cycle as start wins; out-of-range counts are ignored
        start_ok     = start && !stop && (numSlots != '0) && (numSlots <= NSLOTS_N);
        is_last      = ({1'b0, idx} == (n_reg - ONE_N));
        if (!is_last) begin
            adv_state = ISSUE;
            adv_idx   = idx + ONE_A;
        end else if (loop) begin
            adv_state = ISSUE;
            adv_idx   = '0;
        end else begin
            adv_state = FINISH;
            adv_idx   = '0;
        end
    end

    // Slot table: written from the config side in any state. A write that
    // collides with an issue of the same slot lands after the read, so the
    // old value goes out on this pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSLOTS; i++) begin
                tbl_ph[i]    <= '0;
                tbl_dwell[i] <= '0;
            end
        end else if (cfgWe) begin
            tbl_ph[cfgAddr]    <= cfgPhInc;
            tbl_dwell[cfgAddr] <= cfgDwell;
        end
    end

    // Hop sequencer FSM with registered DDS-facing outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            n_reg    <= '0;
            cnt      <= '0;
            phInc    <= '0;
            valPhInc <= 1'b0;
            busy     <= 1'b0;
            slot     <= '0;
            done     <= 1'b0;
`ifdef DDS_HOP_PHRST_EN
            phRst    <= 1'b0;
`endif
        end else begin
            // Strobes default low; only ISSUE and FINISH raise them
            valPhInc <= 1'b0;
            done     <= 1'b0;
`ifdef DDS_HOP_PHRST_EN
            phRst    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_ok) begin
                        n_reg <= numSlots;
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (stop) begin
                        // Abort before the strobe; phInc keeps the last frequency
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        phInc    <= cur_ph;
                        valPhInc <= 1'b1;
`ifdef DDS_HOP_PHRST_EN
                        phRst    <= 1'b1;
`endif
                        slot     <= idx;
                        busy     <= 1'b1;
                        cnt      <= cnt_load;
                        if (single_cycle) begin
                            idx   <= adv_idx;
                            state <= adv_state;
                        end else begin
                            state <= DWELL;
                        end
                    end
                end

                DWELL: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        busy <= 1'b1;
                        cnt  <= cnt - ONE_D;
                        // cnt == 1 marks the final cycle of this slot's dwell
                        if (cnt == ONE_D) begin
                            idx   <= adv_idx;
                            state <= adv_state;
                        end
                    end
                end

                FINISH: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // busy stays high this cycle and drops one cycle after done
                        done  <= 1'b1;
                        busy  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_hop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_hop_sequencer
// Description : Self-checking bench for dds_hop_sequencer. The reference
//               model is a time-line schedule: it places each strobe at the
//               running sum of effective dwells and derives the done and busy
//               windows from those sums. A stop truncates everything from
//               its effect cycle onward.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_hop_sequencer;

    localparam int PW       = 16;
    localparam int DW       = 16;
    localparam int NS       = 8;
    localparam int AW       = 3;
    localparam int MAXC     = 256;
    localparam int NO_STOP  = 9999;
    localparam int NO_WR    = 9999;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfgWe = 1'b0;
    logic [AW-1:0] cfgAddr = '0;
    logic [PW-1:0] cfgPhInc = '0;
    logic [DW-1:0] cfgDwell = '0;
    logic [AW:0]   numSlots = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] phInc;
    logic          valPhInc;
    logic          busy;
    logic [AW-1:0] slot;
    logic          done;
`ifdef DDS_HOP_PHRST_EN
    logic          phRst;
`endif

    always #5 clk = ~clk;

    dds_hop_sequencer #(
        .PHINCWIDTH (PW),
        .DWELLWIDTH (DW),
        .NSLOTS     (NS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfgWe    (cfgWe),
        .cfgAddr  (cfgAddr),
        .cfgPhInc (cfgPhInc),
        .cfgDwell (cfgDwell),
        .numSlots (numSlots),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .phInc    (phInc),
        .valPhInc (valPhInc),
        .busy     (busy),
        .slot     (slot),
        .done     (done)
`ifdef DDS_HOP_PHRST_EN
        ,
        .phRst    (phRst)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model copy of the table and of the held output values
    logic [PW-1:0] m_ph_tbl [NS];
    logic [DW-1:0] m_dw_tbl [NS];
    logic [PW-1:0] m_ph   = '0;
    logic [AW-1:0] m_slot = '0;

    // Per-cycle words {val, busy, done, slot[2:0], ph[15:0]}
    logic [21:0] exp_w  [MAXC];
    logic [21:0] obs_w  [MAXC];
    logic        obs_prst [MAXC];

    task automatic write_slot(input int a, input logic [PW-1:0] p, input logic [DW-1:0] d);
        @(negedge clk);
        cfgWe    = 1'b1;
        cfgAddr  = AW'(a);
        cfgPhInc = p;
        cfgDwell = d;
        @(negedge clk);
        cfgWe    = 1'b0;
        m_ph_tbl[a] = p;
        m_dw_tbl[a] = d;
    endtask

    // Schedule model: cycle r is the r-th sample after the edge that first
    // may issue slot 0. stop_rel = -1 means stop arrives together with start.
    task automatic build_model(input int n, input bit lp, input int stop_rel,
                               input int wr_rel, input int wa,
                               input logic [PW-1:0] wph, input logic [DW-1:0] wdw,
                               input int ncyc);
        logic          e_val  [MAXC];
        logic          e_busy [MAXC];
        logic          e_done [MAXC];
        logic [PW-1:0] e_ph   [MAXC];
        logic [AW-1:0] e_slot [MAXC];
        logic [PW-1:0] p;
        logic [DW-1:0] d;
        logic [PW-1:0] cur_ph;
        logic [AW-1:0] cur_slot;
        int t, i, dd;
        for (int r = 0; r < MAXC; r++) begin
            e_val[r] = 0; e_busy[r] = 0; e_done[r] = 0; e_ph[r] = '0; e_slot[r] = '0;
        end
        if (n >= 1 && n <= NS) begin
            t = 0;
            i = 0;
            while (t < ncyc) begin
                p  = (t > wr_rel && wa == i) ? wph : m_ph_tbl[i];
                d  = (t > wr_rel && wa == i) ? wdw : m_dw_tbl[i];
                dd = (d == 0) ? 1 : int'(d);
                e_val[t]  = 1;
                e_ph[t]   = p;
                e_slot[t] = AW'(i);
                for (int k = t; k < t + dd && k < ncyc; k++) e_busy[k] = 1;
                t = t + dd;
                i = i + 1;
                if (i == n) begin
                    if (lp) i = 0;
                    else begin
                        if (t < ncyc) begin
                            e_done[t] = 1;
                            e_busy[t] = 1;
                        end
                        break;
                    end
                end
            end
        end
        for (int r = 0; r < ncyc; r++) begin
            if (r >= stop_rel) begin
                e_val[r] = 0; e_busy[r] = 0; e_done[r] = 0;
            end
        end
        cur_ph   = m_ph;
        cur_slot = m_slot;
        for (int r = 0; r < ncyc; r++) begin
            if (e_val[r]) begin
                cur_ph   = e_ph[r];
                cur_slot = e_slot[r];
            end
            exp_w[r] = {e_val[r], e_busy[r], e_done[r], cur_slot, cur_ph};
        end
        m_ph   = cur_ph;
        m_slot = cur_slot;
        if (wr_rel < ncyc) begin
            m_ph_tbl[wa] = wph;
            m_dw_tbl[wa] = wdw;
        end
    endtask

    // Drives one start (plus optional stop / table write) and records samples
    task automatic capture(input int n, input bit lp, input int stop_rel,
                           input int wr_rel, input int wa,
                           input logic [PW-1:0] wph, input logic [DW-1:0] wdw,
                           input int ncyc);
        @(negedge clk);
        numSlots = (AW+1)'(n);
        loop     = lp;
        start    = 1'b1;
        stop     = (stop_rel == -1);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int r = 0; r < ncyc; r++) begin
            if (r == stop_rel) stop = 1'b1;
            if (r == wr_rel) begin
                cfgWe    = 1'b1;
                cfgAddr  = AW'(wa);
                cfgPhInc = wph;
                cfgDwell = wdw;
            end
            @(negedge clk);
            obs_w[r] = {valPhInc, busy, done, slot, phInc};
`ifdef DDS_HOP_PHRST_EN
            obs_prst[r] = phRst;
`else
            obs_prst[r] = valPhInc;
`endif
            stop  = 1'b0;
            cfgWe = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [21:0] o;
        for (int i = 0; i < NS; i++) begin m_ph_tbl[i] = '0; m_dw_tbl[i] = '0; end
        #12;
        o = {valPhInc, busy, done, slot, phInc};
        vectors++;
        if (o !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_held: got %06h want %06h", o, 22'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        o = {valPhInc, busy, done, slot, phInc};
        vectors++;
        if (o !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_released: got %06h want %06h", o, 22'h0);
        end
    endtask

    task automatic test_one_shot();
        write_slot(0, 16'h0100, 16'd3);
        write_slot(1, 16'h0200, 16'd1);
        write_slot(2, 16'h0400, 16'd0);
        build_model(3, 0, NO_STOP, NO_WR, 0, '0, '0, 8);
        capture(3, 0, NO_STOP, NO_WR, 0, '0, '0, 8);
        for (int r = 0; r < 8; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL one_shot cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
        vectors++;
        if ({obs_w[0][21], obs_w[0][15:0]} !== 17'h10100 || {obs_w[3][21], obs_w[3][15:0]} !== 17'h10200 ||
            {obs_w[4][21], obs_w[4][15:0]} !== 17'h10400) begin
            miscompares++;
            $display("FAIL one_shot_strobes: got %06h %06h %06h want strobes 0100/0200/0400", obs_w[0], obs_w[3], obs_w[4]);
        end
        vectors++;
        if (obs_w[5][19] !== 1'b1 || obs_w[6][20] !== 1'b0) begin
            miscompares++;
            $display("FAIL one_shot_done_busy: got done5=%b busy6=%b want 1 0", obs_w[5][19], obs_w[6][20]);
        end
    endtask

    task automatic test_loop_stop();
        write_slot(0, 16'h0AAA, 16'd4);
        write_slot(1, 16'h0BBB, 16'd4);
        build_model(2, 1, 10, NO_WR, 0, '0, '0, 13);
        capture(2, 1, 10, NO_WR, 0, '0, '0, 13);
        for (int r = 0; r < 13; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL loop_stop cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
        vectors++;
        if (obs_w[8][21] !== 1'b1 || obs_w[12][15:0] !== 16'h0AAA || obs_w[10][20] !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_stop_hold: got val8=%b ph12=%h busy10=%b want 1 0aaa 0",
                     obs_w[8][21], obs_w[12][15:0], obs_w[10][20]);
        end
    endtask

    task automatic test_invalid_start();
        build_model(0, 0, NO_STOP, NO_WR, 0, '0, '0, 4);
        capture(0, 0, NO_STOP, NO_WR, 0, '0, '0, 4);
        for (int r = 0; r < 4; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL invalid_zero cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
        build_model(9, 0, NO_STOP, NO_WR, 0, '0, '0, 4);
        capture(9, 0, NO_STOP, NO_WR, 0, '0, '0, 4);
        for (int r = 0; r < 4; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL invalid_nine cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        build_model(2, 0, -1, NO_WR, 0, '0, '0, 5);
        capture(2, 0, -1, NO_WR, 0, '0, '0, 5);
        for (int r = 0; r < 5; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL start_stop_idle cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
    endtask

    task automatic test_write_collision();
        write_slot(0, 16'h0100, 16'd2);
        write_slot(1, 16'h0200, 16'd2);
        build_model(2, 1, 8, 2, 1, 16'h0777, 16'd2, 10);
        capture(2, 1, 8, 2, 1, 16'h0777, 16'd2, 10);
        for (int r = 0; r < 10; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL write_collision cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
        vectors++;
        if (obs_w[2][15:0] !== 16'h0200 || obs_w[6][15:0] !== 16'h0777) begin
            miscompares++;
            $display("FAIL write_collision_vals: got %h %h want 0200 0777", obs_w[2][15:0], obs_w[6][15:0]);
        end
    endtask

    task automatic test_random_one_shot();
        int n, nc;
        for (int it = 0; it < 15; it++) begin
            for (int a = 0; a < NS; a++)
                write_slot(a, PW'($urandom), DW'($urandom_range(0, 4)));
            n  = $urandom_range(1, NS);
            nc = 3;
            for (int a = 0; a < n; a++) nc += (m_dw_tbl[a] == 0) ? 1 : int'(m_dw_tbl[a]);
            build_model(n, 0, NO_STOP, NO_WR, 0, '0, '0, nc);
            capture(n, 0, NO_STOP, NO_WR, 0, '0, '0, nc);
            for (int r = 0; r < nc; r++) begin
                vectors++;
                if (obs_w[r] !== exp_w[r]) begin
                    miscompares++;
                    $display("FAIL rand_one_shot it %0d cyc %0d: got %06h want %06h", it, r, obs_w[r], exp_w[r]);
                end
            end
        end
    endtask

    task automatic test_random_loop();
        int n, sr, wr, wa;
        logic [PW-1:0] wp;
        logic [DW-1:0] wd;
        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < NS; a++)
                write_slot(a, PW'($urandom), DW'($urandom_range(0, 4)));
            n  = $urandom_range(1, NS);
            sr = $urandom_range(0, 40);
            wr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, sr) : NO_WR;
            wa = $urandom_range(0, NS - 1);
            wp = PW'($urandom);
            wd = DW'($urandom_range(0, 4));
            build_model(n, 1, sr, wr, wa, wp, wd, sr + 3);
            capture(n, 1, sr, wr, wa, wp, wd, sr + 3);
            for (int r = 0; r < sr + 3; r++) begin
                vectors++;
                if (obs_w[r] !== exp_w[r]) begin
                    miscompares++;
                    $display("FAIL rand_loop it %0d cyc %0d: got %06h want %06h", it, r, obs_w[r], exp_w[r]);
                end
            end
        end
    endtask

`ifdef DDS_HOP_PHRST_EN
    task automatic test_phrst();
        write_slot(0, 16'h0011, 16'd2);
        write_slot(1, 16'h0022, 16'd1);
        build_model(2, 0, NO_STOP, NO_WR, 0, '0, '0, 6);
        capture(2, 0, NO_STOP, NO_WR, 0, '0, '0, 6);
        for (int r = 0; r < 6; r++) begin
            vectors++;
            if (obs_prst[r] !== exp_w[r][21]) begin
                miscompares++;
                $display("FAIL phrst cyc %0d: got %b want %b", r, obs_prst[r], exp_w[r][21]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_run();
        logic [21:0] o;
        write_slot(0, 16'h1234, 16'd20);
        @(negedge clk);
        numSlots = (AW+1)'(1);
        loop     = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        o = {valPhInc, busy, done, slot, phInc};
        vectors++;
        if (o !== {1'b0, 1'b1, 1'b0, 3'd0, 16'h1234}) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got %06h want %06h", o, {1'b0, 1'b1, 1'b0, 3'd0, 16'h1234});
        end
        #2 reset = 1'b0;
        #1;
        o = {valPhInc, busy, done, slot, phInc};
        vectors++;
        if (o !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %06h want %06h", o, 22'h0);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < NS; i++) begin m_ph_tbl[i] = '0; m_dw_tbl[i] = '0; end
        m_ph   = '0;
        m_slot = '0;
        build_model(1, 0, NO_STOP, NO_WR, 0, '0, '0, 4);
        capture(1, 0, NO_STOP, NO_WR, 0, '0, '0, 4);
        for (int r = 0; r < 4; r++) begin
            vectors++;
            if (obs_w[r] !== exp_w[r]) begin
                miscompares++;
                $display("FAIL reset_mid_rerun cyc %0d: got %06h want %06h", r, obs_w[r], exp_w[r]);
            end
        end
        vectors++;
        if (obs_w[0][21] !== 1'b1 || obs_w[0][15:0] !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_table: got val=%b ph=%h want 1 0000", obs_w[0][21], obs_w[0][15:0]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_one_shot();
        test_loop_stop();
        test_invalid_start();
        test_start_stop_idle();
        test_write_collision();
        test_random_one_shot();
        test_random_loop();
`ifdef DDS_HOP_PHRST_EN
        test_phrst();
`endif
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_hop_sequencer.md
# dds_hop_sequencer

Frequency-hop controller for the DDS block. It holds a small programmable table of phase-increment/dwell pairs and drives the DDS `phInc`/`valPhInc` inputs. Each slot's increment is issued as a one-cycle strobe, held for its dwell time, then the sequencer advances to the next slot, in one-shot or looping mode. It sits between the register/config interface and the DDS and is the only writer of the DDS frequency word.

## Interface
- `PHINCWIDTH`, 16, phase-increment width; must match the DDS.
- `DWELLWIDTH`, 16, dwell counter width in clock cycles.
- `NSLOTS`, 8, table depth; power of two, at least 2; `ADDRW = $clog2(NSLOTS)`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfgWe`  in  1  table write strobe.
- `cfgAddr`  in  ADDRW  table slot to write.
- `cfgPhInc`  in  PHINCWIDTH  phase increment to store.
- `cfgDwell`  in  DWELLWIDTH  dwell cycles to store.
- `numSlots`  in  ADDRW+1  active slot count (1..NSLOTS); sampled at start.
- `loop`  in  1  1 = wrap to slot 0 after the last slot; sampled when the last slot expires.
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `phInc`  out  PHINCWIDTH  to DDS `phInc`; registered.
- `valPhInc`  out  1  to DDS `valPhInc`; one-cycle strobe per slot.
- `busy`  out  1  sequence in progress.
- `slot`  out  ADDRW  index of the slot currently dwelling.
- `done`  out  1  one-cycle pulse when a one-shot sequence completes.

## Operation
- Table: NSLOTS × (PHINCWIDTH+DWELLWIDTH) flops; all entries clear to 0 on reset.
  - Writes are accepted in any state.
  - A write to the slot being issued in the same cycle issues the old value. The new value takes effect on the next issue of that slot.
- Effective dwell is `D = max(dwell, 1)`. A dwell value of 0 is treated as 1.
- FSM states are IDLE, ISSUE, DWELL and FINISH.
  - **IDLE**, on `start`:
    - If `numSlots` is 0 or greater than NSLOTS: ignore `start` and stay in IDLE.
    - Otherwise latch `numSlots` into `nReg`, set idx = 0, and go to ISSUE.
  - **ISSUE:**
    - Drive `phInc <= tbl[idx].phInc`, `valPhInc <= 1` and `slot <= idx`.
    - Load `cnt <= D-1`.
    - If D == 1, advance immediately; otherwise go to DWELL.
  - **DWELL:** decrement `cnt` each cycle; advance when `cnt` reaches 1.
  - **Advance:**
    - If idx < nReg-1: idx++ and go to ISSUE.
    - Else if `loop`: idx = 0 and go to ISSUE.
    - Else go to FINISH.
  - **FINISH:** `done <= 1` for one cycle, then go to IDLE.
- `busy` is 1 in ISSUE, DWELL and FINISH, and 0 in IDLE.
- `stop` while busy:
  - The next state is IDLE and no `done` pulse is issued.
  - `phInc` keeps its last value, so the DDS keeps running at that frequency.
- `stop` and `start` in the same IDLE cycle: `stop` wins and `start` is ignored.
- `start` while busy is ignored (no restart).
- `phInc` changes only in the cycle `valPhInc` is high. It is stable otherwise.

## Timing
- **Reset values:** `phInc = 0`, `valPhInc = 0`, `busy = 0`, `slot = 0`, `done = 0`, state IDLE, idx 0, `cnt` 0.
- **Start latency:** `start` high in cycle N gives `valPhInc` and slot 0's `phInc` registered at the edge ending cycle N+1, with `busy = 1` from the same edge.
- **Dwell spacing:** consecutive `valPhInc` strobes are exactly D(slot) cycles apart, counted edge to edge.
- **One-shot completion:** `done` rises D(last) cycles after the last strobe. `busy` falls one cycle after `done`.
- **Stop latency:** `stop` in cycle N gives `busy = 0` after the next edge. A `valPhInc` is never emitted after that edge.
- Reset deassertion is synchronised by the integrator. The block only requires that `reset` is released away from the `clk` edge.

## Configuration
- **With `DDS_HOP_PHRST_EN` defined:**
  - Adds output `phRst` (1 bit, reset 0).
  - `phRst` pulses together with every `valPhInc`, commanding a DDS phase-accumulator clear for phase-coherent hops.
- **Without `DDS_HOP_PHRST_EN`:** the port and its logic are absent, and the accumulator phase is continuous across hops.

## Test plan
- **Reset mid-run:** assert `reset` low during DWELL.
  - Required: all outputs go to reset values immediately, with no clock needed.
  - Required: table reads back 0 on the next run (`phInc = 0`).
- **One-shot:**
  - Stimulus: table {0x0100/3, 0x0200/1, 0x0400/0}, `numSlots = 3`, `loop = 0`, `start`.
  - Required: strobes with 0x0100, 0x0200, 0x0400 at relative cycles 0, 3, 4.
  - Required: `done` at cycle 5 and `busy` low at cycle 6.
- **Loop and stop:**
  - Stimulus: 2 slots of dwell 4, `loop = 1`. Issue `stop` during the 3rd dwell.
  - Required: strobes at 0, 4, 8 (slot 0 again), then `busy = 0` one cycle after `stop`.
  - Required: no `done` pulse and `phInc` holds slot 0's value.
- **Invalid start:**
  - Stimulus: `numSlots = 0` with `start`, then `numSlots = 9` (NSLOTS = 8) with `start`.
  - Required: `busy` stays 0 and no strobe in either case.
- **Write collision:**
  - Stimulus: write slot 1 = 0x0777 in the same cycle slot 1 issues (old value 0x0200), with `loop = 1`.
  - Required: 0x0200 issued this pass and 0x0777 on the next pass.
- **Simultaneous start and stop in IDLE:** required: no strobe and `busy` stays 0.
